// File: rtl/apb_completer_mem.sv
// APB3 completer with a word-addressed memory bank, programmable wait states,
// error responses for bad or read-only addresses and a sticky protocol-violation flag.
module apb_completer_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RO_WORDS   = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [3:0]            wait_cfg,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err,
  output logic [15:0]           xfer_count
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, PERR} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] sel_addr, offset, word;
  logic                  sel_write, in_range, sel_err;
  logic [IDX_W-1:0]      sel_idx;
  logic [DATA_WIDTH-1:0] sel_rdata;

  // In IDLE the live bus is decoded so a zero-wait response can be registered at
  // the setup edge; afterwards only the latched transfer is decoded.
  always_comb begin
    sel_addr  = (state == IDLE) ? PADDR  : lat_addr;
    sel_write = (state == IDLE) ? PWRITE : lat_write;
    offset    = sel_addr - BASE_ADDR;
    word      = offset >> LSB;
    in_range  = (sel_addr >= BASE_ADDR) && (word < ADDR_WIDTH'(DEPTH)) &&
                ((sel_addr & ALIGN_MASK) == '0);
    sel_idx   = word[IDX_W-1:0];
    sel_err   = !in_range || (sel_write && (word < ADDR_WIDTH'(RO_WORDS)));
    sel_rdata = (in_range && !sel_write) ? mem[sel_idx] : '0;
  end

  // NOTE: every register here, including the bank, updates with non-blocking
  // assignments so all reads in this block see pre-edge values.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      PRDATA     <= '0;
      PREADY     <= 1'b0;
      PSLVERR    <= 1'b0;
      proto_err  <= 1'b0;
      xfer_count <= '0;
      // NOTE: the bank is deliberately in the reset domain because its
      // post-reset contents are part of the block's contract.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i < RO_WORDS) ? DATA_WIDTH'(i) : '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            lat_addr  <= PADDR;
            lat_write <= PWRITE;
            lat_wdata <= PWDATA;
            cnt       <= wait_cfg;
            state     <= ACCESS;
            if (wait_cfg == 4'd0) begin
              PREADY  <= 1'b1;
              PSLVERR <= sel_err;
              PRDATA  <= sel_rdata;
            end
          end else if (PSEL && PENABLE) begin
            // Access phase without a setup: answer with an error, touch nothing.
            proto_err <= 1'b1;
            PREADY    <= 1'b1;
            PSLVERR   <= 1'b1;
            PRDATA    <= '0;
            state     <= PERR;
          end
        end

        PERR: begin
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          state   <= IDLE;
        end

        ACCESS: begin
          if (!PSEL) begin
            proto_err <= 1'b1;
            PREADY    <= 1'b0;
            PSLVERR   <= 1'b0;
            PRDATA    <= '0;
            state     <= IDLE;
          end else begin
            if (PADDR != lat_addr || PWRITE != lat_write || PWDATA != lat_wdata) begin
              proto_err <= 1'b1;
            end
            if (PENABLE) begin
              if (PREADY) begin
                if (lat_write && !sel_err) begin
                  mem[sel_idx] <= lat_wdata;
                end
                xfer_count <= xfer_count + 16'd1;
                PREADY     <= 1'b0;
                PSLVERR    <= 1'b0;
                PRDATA     <= '0;
                state      <= IDLE;
              end else begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                  PREADY  <= 1'b1;
                  PSLVERR <= sel_err;
                  PRDATA  <= sel_rdata;
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_completer_mem.sv
// Scoreboarded bench for apb_completer_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever PREADY is high.
module tb_apb_completer_mem;

  localparam int          DEPTH = 64;
  localparam int          RO    = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  wait_cfg;
  logic        PREADY, PSLVERR, proto_err;
  logic [15:0] xfer_count;

  apb_completer_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .BASE_ADDR(BASE), .RO_WORDS(RO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .wait_cfg(wait_cfg), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .proto_err(proto_err), .xfer_count(xfer_count)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] model_mem [DEPTH];
  int          model_count;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bank as the protocol describes it: words, a read-only prefix, and range/alignment rules.
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = (i < RO) ? i : 0;
    model_count = 0;
  endtask

  function automatic bit model_valid(input logic [31:0] addr);
    return (addr >= BASE) && (addr % 4 == 0) && (((addr - BASE) / 4) < DEPTH);
  endfunction

  function automatic resp_t model_resp(input logic [31:0] addr, input logic wr);
    resp_t       r;
    int unsigned idx;
    bit          ok;
    ok      = model_valid(addr);
    idx     = (addr - BASE) / 4;
    r.err   = !ok || (wr && idx < RO);
    r.rdata = (ok && !wr) ? model_mem[idx] : 32'h0;
    return r;
  endfunction

  // Called at posedge+1; returns at completion edge+1 so transfers can run back to back.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] w, input bit glitch);
    resp_t r;
    int    lat;
    r = model_resp(addr, wr);
    exp_q.push_back(r);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; wait_cfg = w;
    @(posedge PCLK); #1;
    PENABLE  = 1'b1;
    wait_cfg = 4'($urandom);
    if (glitch) begin
      PADDR  = $urandom;
      PWDATA = $urandom;
      PWRITE = ~wr;
    end
    lat = 1;
    while (!PREADY && lat < 40) begin
      @(posedge PCLK); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(1 + w));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("pready_one_cycle", 64'(PREADY), 64'd0);
    if (wr && !r.err) model_mem[(addr - BASE) / 4] = wd;
    model_count++;
    check("xfer_count", 64'(xfer_count), 64'(model_count[15:0]));
  endtask

  always @(negedge PCLK) begin
    resp_t e;
    if (!PRESET) begin
      if (PREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready: PREADY=1 with no transfer pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("prdata", 64'(PRDATA), 64'(e.rdata));
          check("pslverr", 64'(PSLVERR), 64'(e.err));
        end
      end else begin
        check("outputs_quiet", 64'({PSLVERR, PRDATA}), 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        wr;
    int          cnt_before;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; wait_cfg = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready", 64'(PREADY), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_prdata", 64'(PRDATA), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_xfer_count", 64'(xfer_count), 64'd0);
    @(negedge PCLK) PRESET = 1'b0;
    @(posedge PCLK); #1;

    // Basic write/read, zero wait states.
    xfer(32'h10, 1'b1, 32'hDEAD_BEEF, 4'd0, 1'b0);
    xfer(32'h10, 1'b0, 32'h0, 4'd0, 1'b0);
    check("count_after_two", 64'(xfer_count), 64'd2);

    // Read-only region.
    xfer(32'h08, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h08, 1'b1, 32'h1234, 4'd0, 1'b0);
    xfer(32'h08, 1'b0, 32'h0, 4'd0, 1'b0);

    // Out of range and misaligned, then confirm word 0x10 untouched.
    xfer(32'h100, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h100, 1'b1, 32'h5555_AAAA, 4'd1, 1'b0);
    xfer(32'h11, 1'b1, 32'h7777_7777, 4'd0, 1'b0);
    xfer(32'h11, 1'b0, 32'h0, 4'd2, 1'b0);
    xfer(32'h10, 1'b0, 32'h0, 4'd0, 1'b0);

    // Long wait; wait_cfg is scrambled after setup inside xfer.
    xfer(32'h10, 1'b0, 32'h0, 4'd5, 1'b0);
    check("proto_err_clean", 64'(proto_err), 64'd0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
        1:       a = 32'($urandom_range(0, RO - 1)) * 4;
        2:       a = 32'h100 + 32'($urandom_range(0, 255)) * 4;
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
      endcase
      wr = 1'($urandom);
      xfer(a, wr, $urandom, 4'($urandom_range(0, 3)), 1'b0);
    end
    check("proto_err_after_random", 64'(proto_err), 64'd0);

    // Bus changes during access: latched values must win.
    xfer(32'h30, 1'b1, 32'hCAFE_0001, 4'd2, 1'b1);
    check("proto_err_glitch", 64'(proto_err), 64'd1);
    xfer(32'h30, 1'b0, 32'h0, 4'd0, 1'b0);

    // Access phase from IDLE with no setup.
    cnt_before = model_count;
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 32'h14; PWRITE = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    @(posedge PCLK); #1;
    check("viol_pready", 64'(PREADY), 64'd1);
    check("viol_proto_err", 64'(proto_err), 64'd1);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("viol_pready_drop", 64'(PREADY), 64'd0);
    check("viol_no_count", 64'(xfer_count), 64'(cnt_before));

    // PSEL dropped mid-wait on a write: no write, back in IDLE.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h24; PWRITE = 1'b1; PWDATA = 32'hA5A5_A5A5;
    wait_cfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    check("abort_pready", 64'(PREADY), 64'd0);
    check("abort_no_count", 64'(xfer_count), 64'(model_count));
    xfer(32'h24, 1'b0, 32'h0, 4'd0, 1'b0);

    // Reset during the wait states of a write.
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h20; PWRITE = 1'b1; PWDATA = 32'h1357_9BDF;
    wait_cfg = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    #3;
    PRESET = 1'b1;
    #1;
    check("midrst_pready", 64'(PREADY), 64'd0);
    check("midrst_xfer_count", 64'(xfer_count), 64'd0);
    check("midrst_proto_err", 64'(proto_err), 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    model_reset();
    @(negedge PCLK) PRESET = 1'b0;
    @(posedge PCLK); #1;
    check("postrst_xfer_count", 64'(xfer_count), 64'd0);
    xfer(32'h20, 1'b0, 32'h0, 4'd0, 1'b0);
    xfer(32'h10, 1'b0, 32'h0, 4'd1, 1'b0);
    xfer(32'h0C, 1'b0, 32'h0, 4'd0, 1'b0);

    repeat (2) @(posedge PCLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_completer_mem.md
# apb_completer_mem

APB3 completer (slave) with a word-addressed register/memory bank, a programmable wait-state counter, and error responses for bad addresses. It sits on the APB side of the AHB-to-APB bridge as the target that the bridge's APB requester drives. It provides the responder end of the protocol, so bridge transfers can be checked end to end against known memory contents and known PREADY/PSLVERR timing.

## Interface
- ADDR_WIDTH, 32: PADDR width.
- DATA_WIDTH, 32: PWDATA/PRDATA width; byte lanes per word = DATA_WIDTH/8 (power of two).
- DEPTH, 64: number of words in the bank.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- RO_WORDS, 4: words 0..RO_WORDS-1 are read-only.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  completer select.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- wait_cfg  in  4  wait states inserted per transfer, sampled in the setup cycle.
- PRDATA  out  DATA_WIDTH  read data; 0 whenever PREADY=0 or the transfer is a write.
- PREADY  out  1  registered transfer-complete.
- PSLVERR  out  1  error response; valid only while PREADY=1, else 0.
- proto_err  out  1  sticky protocol-violation flag.
- xfer_count  out  16  count of completed transfers, including errored ones; wraps 0xFFFF→0.

## Operation
- Word index = (PADDR − BASE_ADDR) >> log2(DATA_WIDTH/8).
- A transfer is valid when all of the following hold: PADDR ≥ BASE_ADDR, the index is below DEPTH, and the low log2(DATA_WIDTH/8) address bits are 0. Otherwise it completes with PSLVERR=1, no write, and PRDATA=0.
- A write to the read-only region completes with PSLVERR=1 and leaves the word unchanged. Reads of the read-only region are legal.
- FSM states:
  - IDLE, on PSEL=1 & PENABLE=0 (setup): latch PADDR, PWRITE, PWDATA; load cnt=wait_cfg; go to ACCESS. If wait_cfg=0, PREADY←1 on the same edge.
  - ACCESS, with PSEL & PENABLE & !PREADY: cnt←cnt−1. When cnt reaches 1, PREADY←1 on the next edge.
  - ACCESS, with PSEL & PENABLE & PREADY (completion edge): commit the write if legal; xfer_count+1; PREADY←0; go to IDLE.
- PRDATA and PSLVERR are computed from the latched address and latched direction, and are driven in the cycle where PREADY=1.
- Back-to-back transfers are supported: the cycle after completion may be a new setup, which IDLE accepts.
- Protocol violations set proto_err, which is cleared only by PRESET:
  - PSEL & PENABLE in IDLE with no preceding setup: no access; respond one cycle later with PREADY=1 and PSLVERR=1; no count.
  - PSEL dropping in ACCESS before completion: abort, return to IDLE, no write, no count.
  - PADDR, PWRITE or PWDATA changing during ACCESS: the transfer completes using the latched values.

## Timing
- Reset values: PREADY=0, PSLVERR=0, PRDATA=0, proto_err=0, xfer_count=0, FSM=IDLE.
- Bank reset contents: word i = i for i < RO_WORDS; all other words = 0.
- Latency: PREADY rises at setup edge + 1 + wait_cfg cycles. With wait_cfg=0, PREADY is high in the first access cycle, so a transfer takes 2 cycles.
- PREADY holds high for exactly one cycle per transfer.
- Write data is visible to a read whose setup occurs in the cycle after the write completes.
- A change to wait_cfg after the setup cycle does not affect the transfer in flight.
- PRESET asserted mid-transfer: outputs return to their reset values immediately (asynchronously), the bank is reinitialised, and the pending write is lost.

## Test plan
- Reset, then write 32'hDEAD_BEEF to 0x10 and read 0x10, wait_cfg=0 → each transfer takes 2 cycles; read returns 32'hDEAD_BEEF with PSLVERR=0; xfer_count=2.
- Read 0x08 after reset, then write 32'h1234 to 0x08 → the read returns 32'h2; the write gets PSLVERR=1; a re-read returns 32'h2.
- Access address 0x100 (index 64) and misaligned 0x11 → PREADY with PSLVERR=1, PRDATA=0, memory unchanged, xfer_count increments.
- wait_cfg=5 on a read of 0x10 → PREADY rises exactly 6 cycles after the setup edge; changing wait_cfg to 0 mid-transfer has no effect.
- Assert PSEL & PENABLE from IDLE with no setup → proto_err=1, one-cycle PREADY with PSLVERR=1, xfer_count unchanged. Separately, drop PSEL mid-wait on a write → no write, FSM in IDLE.
- Assert PRESET during the wait states of a write to 0x20 → PREADY=0 immediately; after release, a read of 0x20 returns 0 and xfer_count=0.
